// File: rtl/axi_slave_ctrl_fsm_if.sv
// AXI4-Lite bus bundle between a bus master and axi_slave_ctrl_fsm.
// Holds the AR/R and AW/W/B channel signals. The master modport drives the
// request side and the slave modport drives the ready/response side.
interface axi_slave_ctrl_fsm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  AWvalid;
    logic                  AWready;
    logic [ADDR_W-1:0]     AWaddr;
    logic                  Wvalid;
    logic                  Wready;
    logic [DATA_W-1:0]     Wdata;
    logic [DATA_W/8-1:0]   Wstrb;
    logic                  Bvalid;
    logic                  Bready;
    logic [1:0]            Bresp;
    logic                  ARvalid;
    logic                  ARready;
    logic [ADDR_W-1:0]     ARaddr;
    logic                  Rvalid;
    logic                  Rready;
    logic [DATA_W-1:0]     Rdata;
    logic [1:0]            Rresp;

    modport master (
        output AWvalid, AWaddr, Wvalid, Wdata, Wstrb, Bready, ARvalid, ARaddr, Rready,
        input  AWready, Wready, Bvalid, Bresp, ARready, Rvalid, Rdata, Rresp
    );

    modport slave (
        input  AWvalid, AWaddr, Wvalid, Wdata, Wstrb, Bready, ARvalid, ARaddr, Rready,
        output AWready, Wready, Bvalid, Bresp, ARready, Rvalid, Rdata, Rresp
    );
endinterface

// File: rtl/axi_slave_ctrl_fsm.sv
// axi_slave_ctrl_fsm: AXI4-Lite slave control FSM for register blocks.
// One transaction outstanding at a time. Reads and writes are granted
// alternately when both are pending. A programmable number of wait states
// (wait_cfg, sampled at address accept) precedes each register strobe.
// Optional macro AXI_SLV_DECERR_EN: addresses >= ADDR_LIMIT skip the
// register strobe and answer DECERR (read data forced to zero).
module axi_slave_ctrl_fsm #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                WAIT_W     = 4,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 'h100
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WAIT_W-1:0]     wait_cfg,
    axi_slave_ctrl_fsm_if.slave   axi,
    output logic                  reg_wr_en,
    output logic [ADDR_W-1:0]     reg_wr_addr,
    output logic [DATA_W-1:0]     reg_wr_data,
    output logic [DATA_W/8-1:0]   reg_wr_strb,
    output logic                  reg_rd_en,
    output logic [ADDR_W-1:0]     reg_rd_addr,
    input  logic [DATA_W-1:0]     reg_rd_data,
    input  logic                  reg_err
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_WAIT    = 3'd1,
        RD_RESP    = 3'd2,
        WR_COLLECT = 3'd3,
        WR_WAIT    = 3'd4,
        WR_RESP    = 3'd5
    } state_t;

`ifdef AXI_SLV_DECERR_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t            state;
    state_t            state_nx;
    logic              last_wr;    // 1 when the most recent grant went to the write side
    logic [WAIT_W-1:0] cnt;
    logic              aw_got;
    logic              w_got;

    logic rd_req;
    logic wr_req;
    logic grant_rd;
    logic grant_wr;
    logic ar_hs;
    logic aw_hs;
    logic w_hs;
    logic cnt_zero;
    logic rd_acc;
    logic wr_acc;
    logic rd_dec;
    logic wr_dec;

    function automatic logic [1:0] resp_code(input logic dec, input logic err);
        if (dec)
            return RESP_DECERR;
        else if (err)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

    assign rd_req   = axi.ARvalid;
    assign wr_req   = axi.AWvalid | axi.Wvalid;
    // On a tie the side that did not win last time gets the bus.
    assign grant_rd = rd_req && (!wr_req || last_wr);
    assign grant_wr = wr_req && !grant_rd;

    assign ar_hs    = axi.ARvalid && axi.ARready;
    assign aw_hs    = axi.AWvalid && axi.AWready;
    assign w_hs     = axi.Wvalid  && axi.Wready;

    assign cnt_zero = (cnt == '0);
    assign rd_acc   = (state == RD_WAIT) && cnt_zero;
    assign wr_acc   = (state == WR_WAIT) && cnt_zero;
    assign rd_dec   = DEC_EN && (reg_rd_addr >= ADDR_LIMIT);
    assign wr_dec   = DEC_EN && (reg_wr_addr >= ADDR_LIMIT);

    // State register: synchronous active-low reset returns to IDLE.
    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_rd)
                    state_nx = RD_WAIT;
                else if (grant_wr)
                    state_nx = WR_COLLECT;
            end
            RD_WAIT: begin
                if (cnt_zero)
                    state_nx = RD_RESP;
            end
            RD_RESP: begin
                if (axi.Rready)
                    state_nx = IDLE;
            end
            WR_COLLECT: begin
                if ((aw_got || aw_hs) && (w_got || w_hs))
                    state_nx = WR_WAIT;
            end
            WR_WAIT: begin
                if (cnt_zero)
                    state_nx = WR_RESP;
            end
            WR_RESP: begin
                if (axi.Bready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and strobe outputs decoded from the current state.
    // Strobes are held off in a cycle where reset is asserted, so an aborted
    // transaction never touches the register file.
    always_comb begin
        axi.ARready = 1'b0;
        axi.AWready = 1'b0;
        axi.Wready  = 1'b0;
        axi.Rvalid  = 1'b0;
        axi.Bvalid  = 1'b0;
        reg_rd_en   = 1'b0;
        reg_wr_en   = 1'b0;
        case (state)
            IDLE:       axi.ARready = grant_rd;
            RD_WAIT:    reg_rd_en   = cnt_zero && !rd_dec && reset;
            RD_RESP:    axi.Rvalid  = 1'b1;
            WR_COLLECT: begin
                axi.AWready = !aw_got;
                axi.Wready  = !w_got;
            end
            WR_WAIT:    reg_wr_en   = cnt_zero && !wr_dec && reset;
            WR_RESP:    axi.Bvalid  = 1'b1;
            default:    ;
        endcase
    end

    // Control state: grant history, wait-state counter and AW/W capture flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_wr <= 1'b1;
            cnt     <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aw_got <= 1'b0;
                    w_got  <= 1'b0;
                    if (grant_rd) begin
                        last_wr <= 1'b0;
                        cnt     <= wait_cfg;
                    end else if (grant_wr) begin
                        last_wr <= 1'b1;
                    end
                end
                WR_COLLECT: begin
                    if (aw_hs) begin
                        aw_got <= 1'b1;
                        cnt    <= wait_cfg;
                    end
                    if (w_hs)
                        w_got <= 1'b1;
                end
                RD_WAIT, WR_WAIT: begin
                    if (!cnt_zero)
                        cnt <= cnt - WAIT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Captured addresses/data and registered responses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            reg_rd_addr <= '0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            reg_wr_strb <= '0;
            axi.Rdata   <= '0;
            axi.Rresp   <= RESP_OKAY;
            axi.Bresp   <= RESP_OKAY;
        end else begin
            if (ar_hs)
                reg_rd_addr <= axi.ARaddr;
            if (aw_hs)
                reg_wr_addr <= axi.AWaddr;
            if (w_hs) begin
                reg_wr_data <= axi.Wdata;
                reg_wr_strb <= axi.Wstrb;
            end
            if (rd_acc) begin
                axi.Rdata <= rd_dec ? '0 : reg_rd_data;
                axi.Rresp <= resp_code(rd_dec, reg_err);
            end
            if (wr_acc)
                axi.Bresp <= resp_code(wr_dec, reg_err);
        end
    end
endmodule

// File: doc/axi_slave_ctrl_fsm.md
Name: axi_slave_ctrl_fsm

Overview:
- Parametrised AXI4-Lite slave control FSM for GPIO and peripheral register blocks.
- Handles the AR/R and AW/W/B channels and applies a runtime-programmable wait-state count (wait_cfg).
- Generates single-cycle register-file strobes and registered responses with OKAY/SLVERR.
- Arbitrates simultaneous read and write requests fairly (alternating grant).

Parameters:
- ADDR_W, 32, width of AWaddr/ARaddr and reg_*_addr.
- DATA_W, 32, width of Wdata/Rdata and register data; must be a multiple of 8.
- WAIT_W, 4, width of wait_cfg; maximum wait states is 2**WAIT_W-1.
- ADDR_LIMIT, 32'h0000_0100, first illegal byte address; used only with AXI_SLV_DECERR_EN.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low.
- wait_cfg  in  WAIT_W  wait states inserted before register access; sampled at address accept.
- AWvalid/AWready  in/out  1  write-address handshake.
- AWaddr  in  ADDR_W  write address.
- Wvalid/Wready  in/out  1  write-data handshake.
- Wdata  in  DATA_W  write data.
- Wstrb  in  DATA_W/8  byte strobes.
- Bvalid/Bready  out/in  1  write-response handshake.
- Bresp  out  2  write response.
- ARvalid/ARready  in/out  1  read-address handshake.
- ARaddr  in  ADDR_W  read address.
- Rvalid/Rready  out/in  1  read-data handshake.
- Rdata  out  DATA_W  read data.
- Rresp  out  2  read response.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_addr  out  ADDR_W  captured write address.
- reg_wr_data  out  DATA_W  captured write data.
- reg_wr_strb  out  DATA_W/8  captured write strobes.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_addr  out  ADDR_W  captured read address.
- reg_rd_data  in  DATA_W  register read data, valid in the reg_rd_en cycle.
- reg_err  in  1  register-side error, sampled with reg_rd_en/reg_wr_en.

Behaviour:
- Reset (reset==0 at clock edge):
  - State to IDLE; last_grant to WRITE, so read wins the first tie.
  - All outputs to 0: ready/valid signals, Bresp/Rresp, Rdata, reg_* outputs.
  - Applies from any state and aborts any transaction in flight; no reg_*_en is issued for an aborted transaction.
- States: IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP. Encoding is free; illegal states go to IDLE on the next edge.
- IDLE:
  - rd_req = ARvalid; wr_req = AWvalid | Wvalid.
  - Both requests: grant the opposite of last_grant. Single request: grant it.
  - Grant is updated on the transition out of IDLE.
  - ARready is combinational, = (state==IDLE && read granted).
  - Read grant: AR handshake captures ARaddr and wait_cfg into cnt; next state RD_WAIT.
  - Write grant: next state WR_COLLECT. No AW/W capture occurs in IDLE.
- RD_WAIT:
  - cnt decrements each cycle.
  - In the cycle cnt==0: reg_rd_en=1; Rdata<=reg_rd_data; Rresp<=reg_err?2'b10:2'b00; next state RD_RESP.
  - wait_cfg=0 gives one RD_WAIT cycle.
  - Latency from AR handshake edge to Rvalid high is wait_cfg+2 edges.
- RD_RESP:
  - Rvalid=1; Rdata and Rresp are held stable.
  - Stays until Rready; on Rvalid&&Rready go to IDLE with Rvalid low next cycle.
- WR_COLLECT:
  - AWready=1 until AW is captured; Wready=1 until W is captured. These are independent flags and both may capture in the same cycle.
  - wait_cfg is sampled at AW capture.
  - When both are captured: next state WR_WAIT, both readies drop.
  - The same handshake never captures twice.
- WR_WAIT:
  - Same counting as RD_WAIT.
  - At cnt==0: reg_wr_en=1 for one cycle with the captured addr/data/strb presented; Bresp<=reg_err?2'b10:2'b00; next state WR_RESP.
- WR_RESP:
  - Bvalid=1 until Bready, then go to IDLE.
- Ordering and limits:
  - Exactly one transaction outstanding; no read/write overlap.
  - reg_*_addr/data hold their last captured value between strobes.
  - Back-to-back: a new request seen in the same cycle the response handshake completes is not accepted until the following IDLE cycle.

Optional Feature:
- Macro AXI_SLV_DECERR_EN.
- Defined:
  - A captured address >= ADDR_LIMIT suppresses reg_rd_en/reg_wr_en for that transaction.
  - The response is DECERR (2'b11) and Rdata=0.
  - Timing is identical to a normal access.
- Undefined: every address performs the register access; responses are only 2'b00 or 2'b10.

Test Plan:
- Read, wait_cfg=3, ARaddr=0x10, reg_rd_data=0xA5A5_0001, Rready=1 -> ARready 1 cycle; reg_rd_en one pulse; Rvalid 5 edges after AR handshake; Rdata=0xA5A5_0001; Rresp=00.
- Write with W one cycle before AW, wait_cfg=0, Wdata=0x1234, Wstrb=4'b0011 -> Wready then AWready; single reg_wr_en with addr/data/strb correct; Bvalid; Bresp=00.
- ARvalid and AWvalid/Wvalid asserted continuously from reset -> grant order R,W,R,W.
- Rready held low 10 cycles with reg_err=1 at strobe -> Rvalid and Rdata stable throughout; Rresp=10; IDLE one cycle after handshake.
- reset=0 pulsed during WR_WAIT (cnt=2) -> no reg_wr_en; next cycle all outputs 0, state IDLE; next write completes normally.
- With AXI_SLV_DECERR_EN, ARaddr=0x200 -> no reg_rd_en; Rresp=11; Rdata=0.
